// File: rtl/aquila_dbus_router.sv
// -----------------------------------------------------------------------------
// aquila_dbus_router
//   Routes data-bus requests from the Aquila core to one of N_SLAVES
//   memory-mapped targets using a static, priority-ordered region table.
//   Only one transaction is tracked at a time. Unmapped addresses and targets
//   that never answer get an error response.
//
// Ports
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   p_strobe_i .. p_data_i  core request (one-cycle strobe + fields)
//   p_ready_o, p_data_o,    one-cycle response pulse, read data, error flag
//   p_error_o
//   busy_o                  a target access is outstanding
//   m_strobe_o              one-hot request pulse to the selected target
//   m_addr_o .. m_data_o    latched request fields, shared by all targets
//   m_ready_i, m_data_i     per-target done and read data (slice k = target k)
//   err_count_o             saturating count of error responses
// -----------------------------------------------------------------------------
module aquila_dbus_router #(
    parameter int XLEN           = 32,
    parameter int N_SLAVES       = 4,
    parameter logic [N_SLAVES*XLEN-1:0] REGION_BASE =
        {32'hF000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000},
    parameter logic [N_SLAVES*XLEN-1:0] REGION_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'hF000_0000},
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     p_strobe_i,
    input  logic [XLEN-1:0]          p_addr_i,
    input  logic                     p_rw_i,
    input  logic [XLEN/8-1:0]        p_byte_enable_i,
    input  logic [XLEN-1:0]          p_data_i,
    output logic                     p_ready_o,
    output logic [XLEN-1:0]          p_data_o,
    output logic                     p_error_o,
    output logic                     busy_o,
    output logic [N_SLAVES-1:0]      m_strobe_o,
    output logic [XLEN-1:0]          m_addr_o,
    output logic                     m_rw_o,
    output logic [XLEN/8-1:0]        m_byte_enable_o,
    output logic [XLEN-1:0]          m_data_o,
    input  logic [N_SLAVES-1:0]      m_ready_i,
    input  logic [N_SLAVES*XLEN-1:0] m_data_i,
    output logic [7:0]               err_count_o
);

    localparam int BE_W  = XLEN / 8;
    localparam int SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [N_SLAVES-1:0]   m_strobe_q, m_strobe_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic                  rw_q, rw_d;
    logic [BE_W-1:0]       be_q, be_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  hit;
    logic [SEL_W-1:0]      hit_idx;
    logic                  sel_ready;
    logic [XLEN-1:0]       sel_rdata;

    // Scan from the highest index down so the lowest matching region is the
    // last one written and therefore wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = N_SLAVES - 1; k >= 0; k--) begin
            if ((p_addr_i & REGION_MASK[k*XLEN +: XLEN]) == REGION_BASE[k*XLEN +: XLEN]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(k);
            end
        end
    end

    // Only the selected target's handshake is ever looked at.
    assign sel_ready = m_ready_i[sel_q];
    assign sel_rdata = m_data_i[int'(sel_q)*XLEN +: XLEN];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        m_strobe_d  = '0;
        addr_d      = addr_q;
        rw_d        = rw_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        err_count_d = err_count_q;

        case (state_q)
            S_IDLE: begin
                if (p_strobe_i) begin
                    if (hit) begin
                        sel_d               = hit_idx;
                        addr_d              = p_addr_i;
                        rw_d                = p_rw_i;
                        be_d                = p_byte_enable_i;
                        wdata_d             = p_data_i;
                        m_strobe_d[hit_idx] = 1'b1;
                        cnt_d               = '0;
                        state_d             = S_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                // A ready in the same cycle the timeout would expire still
                // completes normally.
                if (sel_ready) begin
                    rdata_d = rw_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Count the error on entry to RESP so it is visible with the response.
        if ((state_q != S_RESP) && (state_d == S_RESP) && err_d && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            m_strobe_q  <= '0;
            addr_q      <= '0;
            rw_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            m_strobe_q  <= m_strobe_d;
            addr_q      <= addr_d;
            rw_q        <= rw_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            err_count_q <= err_count_d;
        end
    end

    assign p_ready_o       = (state_q == S_RESP);
    assign p_error_o       = (state_q == S_RESP) && err_q;
    assign p_data_o        = (state_q == S_RESP) ? rdata_q : '0;
    assign busy_o          = (state_q == S_WAIT);
    assign m_strobe_o      = m_strobe_q;
    assign m_addr_o        = addr_q;
    assign m_rw_o          = rw_q;
    assign m_byte_enable_o = be_q;
    assign m_data_o        = wdata_q;
    assign err_count_o     = err_count_q;

endmodule

// File: tb/tb_aquila_dbus_router.sv
// -----------------------------------------------------------------------------
// tb_aquila_dbus_router
//   Randomised and directed bench for aquila_dbus_router. Region 0 is widened
//   (mask 0x7000_0000) so that it overlaps region 1 at 0x8xxx_xxxx while still
//   covering the TCM window at 0x0xxx_xxxx; the timeout is shortened to 8.
// -----------------------------------------------------------------------------
module tb_aquila_dbus_router;

    localparam int TO = 8;
    localparam int NCYC = 14;
    localparam logic [127:0] P_BASE =
        {32'hF000_0000, 32'hC000_0000, 32'h8000_0000, 32'h0000_0000};
    localparam logic [127:0] P_MASK =
        {32'hF000_0000, 32'hF000_0000, 32'hC000_0000, 32'h7000_0000};

    // Reference region table, lowest index has priority.
    localparam logic [31:0] REF_BASE [4] =
        '{32'h0000_0000, 32'h8000_0000, 32'hC000_0000, 32'hF000_0000};
    localparam logic [31:0] REF_MASK [4] =
        '{32'h7000_0000, 32'hC000_0000, 32'hF000_0000, 32'hF000_0000};

    logic         clk;
    logic         rst_n;
    logic         p_strobe;
    logic [31:0]  p_addr;
    logic         p_rw;
    logic [3:0]   p_be;
    logic [31:0]  p_wdata;
    logic         p_ready;
    logic [31:0]  p_rdata;
    logic         p_error;
    logic         busy;
    logic [3:0]   m_strobe;
    logic [31:0]  m_addr;
    logic         m_rw;
    logic [3:0]   m_be;
    logic [31:0]  m_wdata;
    logic [3:0]   m_ready;
    logic [127:0] m_rdata_bus;
    logic [7:0]   err_count;

    int total = 0;
    int bad   = 0;

    // Model state: saturating error count and the last accepted request.
    int           exp_err_cnt = 0;
    logic [31:0]  last_addr  = '0;
    logic         last_rw    = 1'b0;
    logic [3:0]   last_be    = '0;
    logic [31:0]  last_wdata = '0;

    aquila_dbus_router #(
        .XLEN           (32),
        .N_SLAVES       (4),
        .REGION_BASE    (P_BASE),
        .REGION_MASK    (P_MASK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .p_strobe_i      (p_strobe),
        .p_addr_i        (p_addr),
        .p_rw_i          (p_rw),
        .p_byte_enable_i (p_be),
        .p_data_i        (p_wdata),
        .p_ready_o       (p_ready),
        .p_data_o        (p_rdata),
        .p_error_o       (p_error),
        .busy_o          (busy),
        .m_strobe_o      (m_strobe),
        .m_addr_o        (m_addr),
        .m_rw_o          (m_rw),
        .m_byte_enable_o (m_be),
        .m_data_o        (m_wdata),
        .m_ready_i       (m_ready),
        .m_data_i        (m_rdata_bus),
        .err_count_o     (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < 4; i++) begin
            if ((a & REF_MASK[i]) == REF_BASE[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_resp"}, 64'({p_ready, p_error, busy, m_strobe, m_rw, m_be}), 64'd0);
        chk({tag, "_pdata"}, 64'(p_rdata), 64'd0);
        chk({tag, "_maddr"}, 64'(m_addr), 64'd0);
        chk({tag, "_mdata"}, 64'(m_wdata), 64'd0);
        chk({tag, "_errcnt"}, 64'(err_count), 64'd0);
    endtask

    // One transaction, entered and left on a falling edge. The request strobe
    // is sampled on the next rising edge (cycle T); loop index c is cycle T+c.
    // The selected target answers in cycle T+1+d; d >= TO means a timeout,
    // and a pulse that still falls inside the window arrives late.
    task automatic do_txn(input logic [31:0] addr, input logic rw, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] fd, input int d,
                          input bit noise);
        int          k;
        int          resp_c;
        bit          e;
        logic [31:0] rd;
        logic [31:0] td [4];
        int          nready;
        int          got_c;
        logic        got_err;
        logic [31:0] got_data;

        for (int i = 0; i < 4; i++) td[i] = $urandom;
        k = decode(addr);
        if (k >= 0) td[k] = fd;
        m_rdata_bus = {td[3], td[2], td[1], td[0]};

        if (k < 0) begin
            resp_c = 1; e = 1'b1; rd = '0;
        end else if (d < TO) begin
            resp_c = 2 + d; e = 1'b0; rd = rw ? 32'd0 : td[k];
        end else begin
            resp_c = 1 + TO; e = 1'b1; rd = '0;
        end
        if (k >= 0) begin
            last_addr = addr; last_rw = rw; last_be = be; last_wdata = wd;
        end
        if (e && exp_err_cnt < 255) exp_err_cnt++;

        p_strobe = 1'b1; p_addr = addr; p_rw = rw; p_be = be; p_wdata = wd;
        m_ready  = '0;
        @(negedge clk);
        nready = 0; got_c = 0; got_err = 1'b0; got_data = '0;
        for (int c = 1; c <= NCYC; c++) begin
            chk("m_strobe", 64'(m_strobe), (k >= 0 && c == 1) ? (64'd1 << k) : 64'd0);
            chk("busy", 64'(busy), 64'(k >= 0 && c < resp_c));
            if (p_ready) begin
                nready++; got_c = c; got_err = p_error; got_data = p_rdata;
            end else begin
                chk("idle_resp", {31'd0, p_error, p_rdata}, 64'd0);
            end
            p_strobe = 1'b0;
            m_ready  = '0;
            if (noise) begin
                for (int j = 0; j < 4; j++)
                    if (j != k && $urandom_range(0, 3) == 0) m_ready[j] = 1'b1;
                // Strobes while the router is not idle must be ignored.
                if (c <= resp_c && $urandom_range(0, 3) == 0) begin
                    p_strobe = 1'b1;
                    p_addr   = 32'h4000_0000 | ($urandom & 32'h00FF_FFFF);
                end
            end
            if (k >= 0 && c == 1 + d) m_ready[k] = 1'b1;
            @(negedge clk);
        end
        p_strobe = 1'b0;
        m_ready  = '0;

        chk("n_ready", 64'(nready), 64'd1);
        chk("ready_cycle", 64'(got_c), 64'(resp_c));
        chk("p_error", 64'(got_err), 64'(e));
        chk("p_data", 64'(got_data), 64'(rd));
        chk("err_count", 64'(err_count), 64'(exp_err_cnt));
        chk("m_addr", 64'(m_addr), 64'(last_addr));
        chk("m_rw_be", 64'({m_rw, m_be}), 64'({last_rw, last_be}));
        chk("m_data", 64'(m_wdata), 64'(last_wdata));
    endtask

    // Reset in the middle of a WAIT to target 3 that never answers.
    task automatic reset_mid_txn();
        p_strobe = 1'b1; p_addr = 32'hF000_0040; p_rw = 1'b1; p_be = 4'hF; p_wdata = 32'hA5A5_5A5A;
        m_ready  = '0;
        @(negedge clk);
        p_strobe = 1'b0;
        chk("rst_pre_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge clk);
        @(negedge clk);
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        exp_err_cnt = 0;
        last_addr = '0; last_rw = 1'b0; last_be = '0; last_wdata = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("rst_no_ready", 64'({p_ready, busy, m_strobe}), 64'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; p_strobe = 1'b0; p_addr = '0; p_rw = 1'b0; p_be = '0; p_wdata = '0;
        m_ready = '0; m_rdata_bus = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // TCM read, target answers in the strobe cycle.
        do_txn(32'h0000_0010, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        // Write to target 2, answer 5 cycles after its strobe.
        do_txn(32'hC000_0004, 1'b1, 4'b0011, 32'h1234_5678, 32'h5555_AAAA, 5, 1'b0);
        // Unmapped.
        do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 32'h0, 0, 1'b0);
        // Timeout on target 3 with a late ready at T+12.
        do_txn(32'hF000_0100, 1'b0, 4'hF, 32'h0, 32'h0BAD_F00D, 11, 1'b0);
        // Target 1 afterwards completes normally.
        do_txn(32'h9000_0020, 1'b0, 4'hF, 32'h0, 32'h0123_4567, 2, 1'b0);
        // Ready in the last cycle before expiry wins over the timeout.
        do_txn(32'hA000_0000, 1'b0, 4'hF, 32'h0, 32'hCAFE_0001, TO - 1, 1'b0);
        // Overlap: 0x8000_0000 matches regions 0 and 1; region 0 wins.
        do_txn(32'h8000_0000, 1'b0, 4'hF, 32'h0, 32'h7777_8888, 1, 1'b0);

        for (int n = 0; n < 200; n++) begin
            do_txn($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                   $urandom, $urandom, $urandom_range(0, 12), 1'b1);
        end

        reset_mid_txn();
        do_txn(32'h0000_0100, 1'b0, 4'hF, 32'h0, 32'h1357_9BDF, 1, 1'b0);

        // Saturation of the error counter.
        for (int n = 0; n < 256; n++) begin
            do_txn(32'h5000_0000 + 32'(n), 1'b0, 4'hF, 32'h0, 32'h0, 0, 1'b0);
        end
        chk("err_sat", 64'(err_count), 64'd255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
